// File: rtl/fb_pkg.sv
// Shared constants, request type and FSM encoding for the framebuffer write engine.
package fb_pkg;

    localparam int ADDR_W       = 19;
    localparam int DATA_W       = 8;
    localparam int FRAME_PIXELS = 307200;
    localparam int FIFO_DEPTH   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_writer_state_t;

endpackage

// File: rtl/fb_req_fifo.sv
// Small synchronous FIFO of pixel write requests; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module fb_req_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  fb_wr_req_t                i_req,
    input  logic                      i_pop,
    output fb_wr_req_t                o_req,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PW = $clog2(DEPTH);

    fb_wr_req_t     r_mem [DEPTH];
    logic [PW:0]    r_wptr;
    logic [PW:0]    r_rptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_count   = r_wptr - r_rptr;
    assign o_full    = (o_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_req     = r_mem[r_rptr[PW-1:0]];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[PW-1:0]] <= i_req;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (PW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write engine driving RAM port B: buffered pixel writes plus full-frame clear.
// Optional FB_WRITER_BOUNDS_CHECK_EN drops out-of-frame writes and raises sticky o_oob_err.
module fb_writer #(
    parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
    parameter int FIFO_DEPTH   = fb_pkg::FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [fb_pkg::ADDR_W-1:0] i_wr_addr,
    input  logic [fb_pkg::DATA_W-1:0] i_wr_data,
    input  logic                      i_clr_start,
    input  logic [fb_pkg::DATA_W-1:0] i_clr_color,
    output logic                      o_busy,
    output logic                      o_clr_done,
    output logic [fb_pkg::ADDR_W-1:0] o_mem_addr,
    output logic [fb_pkg::DATA_W-1:0] o_mem_data,
    output logic                      o_mem_wren
`ifdef FB_WRITER_BOUNDS_CHECK_EN
    , output logic                    o_oob_err
`endif
);

    import fb_pkg::*;

    localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    fb_writer_state_t   r_state;
    logic               r_clr_pend;
    logic               r_clr_fin;
    logic [CW-1:0]      r_pre_cnt;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic [DATA_W-1:0]  r_clr_color;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_fifo_push;
    logic               w_pop;
    logic               w_clr_req;
    logic               w_go_clear;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_pre_left;
    fb_wr_req_t         w_in_req;
    fb_wr_req_t         w_head;

    assign o_wr_ready = !w_full;
    assign w_push     = i_wr_valid && !w_full;
    assign w_in_req   = '{addr: i_wr_addr, data: i_wr_data};
    assign o_busy     = !w_empty || r_clr_pend || (r_state == CLEAR);

`ifdef FB_WRITER_BOUNDS_CHECK_EN
    logic w_in_range;
    assign w_in_range  = (32'(i_wr_addr) < FRAME_PIXELS);
    assign w_fifo_push = w_push && w_in_range;

    // Sticky flag for any accepted request that fell outside the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_oob_err <= 1'b0;
        end else if (w_push && !w_in_range) begin
            o_oob_err <= 1'b1;
        end
    end
`else
    assign w_fifo_push = w_push;
`endif

    // Entries already queued when a clear is requested must go out first; later ones wait.
    assign w_clr_req  = (r_state != CLEAR) && (r_clr_pend || i_clr_start);
    assign w_pre_left = r_clr_pend ? r_pre_cnt : w_count;
    assign w_go_clear = w_clr_req && (w_pre_left == '0);
    assign w_pop      = (r_state != CLEAR) && !w_empty && !w_go_clear;

    fb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_req   (w_in_req),
        .i_pop   (w_pop),
        .o_req   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Write/clear sequencer with registered RAM port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_clr_pend  <= 1'b0;
            r_clr_fin   <= 1'b0;
            r_pre_cnt   <= '0;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            o_clr_done  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_mem_wren  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_fin) begin
                        o_mem_wren <= 1'b0;
                        o_clr_done <= 1'b1;
                        r_clr_fin  <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        o_mem_addr <= r_clr_cnt;
                        o_mem_data <= r_clr_color;
                        o_mem_wren <= 1'b1;
                        o_clr_done <= 1'b0;
                        r_clr_fin  <= (r_clr_cnt == LAST_PIX);
                        if (r_clr_cnt != LAST_PIX) begin
                            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    o_clr_done <= 1'b0;
                    if (w_go_clear) begin
                        r_state     <= CLEAR;
                        r_clr_color <= i_clr_color;
                        r_clr_cnt   <= '0;
                        r_clr_fin   <= 1'b0;
                        r_clr_pend  <= 1'b0;
                        o_mem_wren  <= 1'b0;
                    end else if (w_pop) begin
                        r_state    <= DRAIN;
                        o_mem_addr <= w_head.addr;
                        o_mem_data <= w_head.data;
                        o_mem_wren <= 1'b1;
                        if (w_clr_req) begin
                            r_clr_pend <= 1'b1;
                            r_pre_cnt  <= w_pre_left - CW'(1);
                        end
                    end else begin
                        r_state    <= IDLE;
                        o_mem_wren <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed self-checking bench for fb_writer with a 1024-pixel frame.
module tb_fb_writer;

    localparam int FP = 1024;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clr_start;
    logic [7:0]  clr_color;
    logic        busy;
    logic        clr_done;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
`ifdef FB_WRITER_BOUNDS_CHECK_EN
    logic        oob_err;
`endif

    int checks;
    int errors;

    fb_writer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_clr_start (clr_start),
        .i_clr_color (clr_color),
        .o_busy      (busy),
        .o_clr_done  (clr_done),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .o_mem_wren  (mem_wren)
`ifdef FB_WRITER_BOUNDS_CHECK_EN
        , .o_oob_err (oob_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic found;
        logic seen_bad;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = 19'd0;
        wr_data   = 8'd0;
        clr_start = 1'b0;
        clr_color = 8'd0;
        tick();
        tick();
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(clr_done), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(wr_ready), 32'd1);

        // single write: two clocks to the RAM port, one-cycle strobe
        wr_valid = 1'b1; wr_addr = 19'h00123; wr_data = 8'hE0;
        tick();
        wr_valid = 1'b0;
        check("single_busy", 32'(busy), 32'd1);
        check("single_wren_early", 32'(mem_wren), 32'd0);
        tick();
        check("single_wren", 32'(mem_wren), 32'd1);
        check("single_addr", 32'(mem_addr), 32'h123);
        check("single_data", 32'(mem_data), 32'hE0);
        check("single_busy_end", 32'(busy), 32'd0);
        tick();
        check("single_wren_off", 32'(mem_wren), 32'd0);
        check("single_addr_hold", 32'(mem_addr), 32'h123);

        // streaming: drain keeps pace so ready never drops
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h200 + i); wr_data = 8'(i + 16);
            check("stream_ready", 32'(wr_ready), 32'd1);
            tick();
            if (i > 0) begin
                check("stream_wren", 32'(mem_wren), 32'd1);
                check("stream_addr", 32'(mem_addr), 32'h200 + 32'(i - 1));
                check("stream_data", 32'(mem_data), 32'(i + 15));
            end
        end
        wr_valid = 1'b0;
        tick();
        check("stream_last_addr", 32'(mem_addr), 32'h209);
        check("stream_last_data", 32'(mem_data), 32'd25);
        tick();
        check("stream_idle_wren", 32'(mem_wren), 32'd0);
        check("stream_idle_busy", 32'(busy), 32'd0);

        // full clear with a second request mid-clear that must be ignored
        clr_color = 8'h1C; clr_start = 1'b1;
        tick();
        clr_start = 1'b0; clr_color = 8'h55;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_wren_start", 32'(mem_wren), 32'd0);
        for (int p = 0; p < FP; p++) begin
            tick();
            check("clr_wren", 32'(mem_wren), 32'd1);
            check("clr_addr", 32'(mem_addr), 32'(p));
            check("clr_data", 32'(mem_data), 32'h1C);
            check("clr_done_early", 32'(clr_done), 32'd0);
            clr_start = (p == 10);
        end
        tick();
        check("clr_done_pulse", 32'(clr_done), 32'd1);
        check("clr_wren_end", 32'(mem_wren), 32'd0);
        tick();
        check("clr_done_once", 32'(clr_done), 32'd0);
        check("clr_busy_end", 32'(busy), 32'd0);
        tick();
        check("clr_no_requeue", 32'(mem_wren), 32'd0);

        // ordering: a write queued before the clear request lands first
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0; clr_start = 1'b1; clr_color = 8'h33;
        tick();
        clr_start = 1'b0;
        check("ord_wren", 32'(mem_wren), 32'd1);
        check("ord_addr", 32'(mem_addr), 32'd5);
        check("ord_data", 32'(mem_data), 32'hFF);
        tick();
        check("ord_gap", 32'(mem_wren), 32'd0);
        for (int p = 0; p < FP; p++) begin
            tick();
            check("ord_clr_addr", 32'(mem_addr), 32'(p));
            check("ord_clr_data", 32'(mem_data), 32'h33);
        end
        tick();
        check("ord_done", 32'(clr_done), 32'd1);

        // backpressure during a clear, queued writes follow clr_done in order
        clr_color = 8'h77; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = 19'(32'h300 + k); wr_data = 8'(32'hA0 + k);
            check("bp_ready", 32'(wr_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < FP + 20 && !found; t++) begin
            if (clr_done) found = 1'b1;
            else tick();
        end
        check("bp_done_seen", 32'(found), 32'd1);
        check("bp_done_wren", 32'(mem_wren), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_wren", 32'(mem_wren), 32'd1);
            check("bp_addr", 32'(mem_addr), 32'h300 + 32'(k));
            check("bp_data", 32'(mem_data), 32'hA0 + 32'(k));
        end
        tick();
        check("bp_dropped_fifth", 32'(mem_wren), 32'd0);
        check("bp_busy_end", 32'(busy), 32'd0);

        // reset mid-clear aborts immediately
        clr_color = 8'h44; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int p = 0; p < 1001; p++) tick();
        check("rmc_addr", 32'(mem_addr), 32'd1000);
        check("rmc_wren", 32'(mem_wren), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rmc_wren_off", 32'(mem_wren), 32'd0);
        check("rmc_busy_off", 32'(busy), 32'd0);
        check("rmc_done_off", 32'(clr_done), 32'd0);
        check("rmc_addr_off", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b0;
        seen_bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (mem_wren || clr_done) seen_bad = 1'b1;
        end
        check("rmc_no_resume", 32'(seen_bad), 32'd0);
        check("rmc_ready", 32'(wr_ready), 32'd1);

`ifdef FB_WRITER_BOUNDS_CHECK_EN
        wr_valid = 1'b1; wr_addr = 19'(FP); wr_data = 8'h99;
        tick();
        wr_valid = 1'b0;
        check("oob_err_set", 32'(oob_err), 32'd1);
        check("oob_not_queued", 32'(busy), 32'd0);
        tick();
        check("oob_no_wren", 32'(mem_wren), 32'd0);
        wr_valid = 1'b1; wr_addr = 19'd7; wr_data = 8'h42;
        tick();
        wr_valid = 1'b0;
        tick();
        check("oob_next_wren", 32'(mem_wren), 32'd1);
        check("oob_next_addr", 32'(mem_addr), 32'd7);
        check("oob_next_data", 32'(mem_data), 32'h42);
        check("oob_sticky", 32'(oob_err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
